// File: rtl/morra_match_ctrl.sv
// Match controller for the MorraCinese core: starts the core, collects one
// move per player per round, issues the round as a one-cycle stimulus,
// captures the round/match result and closes the match on a final result
// or when the players stop responding (watchdog abort).
module morra_match_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       START,
  input  logic [3:0] CFG,
  input  logic       P1_VALID,
  input  logic [1:0] P1_MOVE,
  input  logic       P2_VALID,
  input  logic [1:0] P2_MOVE,
  output logic       P1_READY,
  output logic       P2_READY,
  output logic       INIZIO,
  output logic [1:0] PRIMO,
  output logic [1:0] SECONDO,
  input  logic [1:0] MANCHE,
  input  logic [1:0] PARTITA,
  output logic       RES_VALID,
  output logic [1:0] RES_MANCHE,
  output logic [1:0] RES_PARTITA,
  output logic [4:0] ROUND_CNT,
  output logic       BUSY,
  output logic       MATCH_DONE,
  output logic       TIMEOUT
);

  typedef enum logic [2:0] {
    S_IDLE, S_CONFIG, S_COLLECT, S_ISSUE, S_CAPTURE, S_DONE
  } state_t;

  // Last watchdog value before the abort edge: the abort happens on the
  // TIMEOUT_CYCLES-th COLLECT edge of a round.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [1:0]       p1_lat, p2_lat;
  logic             p1_full, p2_full;
  logic [CNT_W-1:0] wd_cnt;
  logic             p1_acc, p2_acc, both_full, wd_expire;

  // Round counter saturates at its maximum instead of wrapping.
  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state, handshake acceptance and core drive decoded from state.
  always_comb begin
    state_nxt  = state;
    P1_READY   = 1'b0;
    P2_READY   = 1'b0;
    INIZIO     = 1'b0;
    PRIMO      = 2'b00;
    SECONDO    = 2'b00;
    BUSY       = 1'b0;
    MATCH_DONE = 1'b0;
    p1_acc     = 1'b0;
    p2_acc     = 1'b0;
    both_full  = 1'b0;
    wd_expire  = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) state_nxt = S_CONFIG;
      end
      S_CONFIG: begin
        BUSY             = 1'b1;
        INIZIO           = 1'b1;
        {SECONDO, PRIMO} = CFG;
        state_nxt        = S_COLLECT;
      end
      S_COLLECT: begin
        BUSY      = 1'b1;
        P1_READY  = !p1_full;
        P2_READY  = !p2_full;
        // A 00 move is not a move: it is ignored and READY stays up.
        p1_acc    = P1_READY && P1_VALID && (P1_MOVE != 2'b00);
        p2_acc    = P2_READY && P2_VALID && (P2_MOVE != 2'b00);
        both_full = (p1_full || p1_acc) && (p2_full || p2_acc);
        wd_expire = (wd_cnt == WD_LAST) && !both_full;
        if (both_full)      state_nxt = S_ISSUE;
        else if (wd_expire) state_nxt = S_DONE;
      end
      S_ISSUE: begin
        BUSY      = 1'b1;
        PRIMO     = p1_lat;
        SECONDO   = p2_lat;
        state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        BUSY      = 1'b1;
        state_nxt = (PARTITA != 2'b00) ? S_DONE : S_COLLECT;
      end
      S_DONE: begin
        MATCH_DONE = 1'b1;
        if (START) state_nxt = S_CONFIG;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Move latches, watchdog, result registers, round counter and abort flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1_lat      <= 2'b00;
      p2_lat      <= 2'b00;
      p1_full     <= 1'b0;
      p2_full     <= 1'b0;
      wd_cnt      <= '0;
      RES_VALID   <= 1'b0;
      RES_MANCHE  <= 2'b00;
      RES_PARTITA <= 2'b00;
      ROUND_CNT   <= 5'd0;
      TIMEOUT     <= 1'b0;
    end else begin
      RES_VALID <= 1'b0;
      case (state)
        S_CONFIG: begin
          p1_lat    <= 2'b00;
          p2_lat    <= 2'b00;
          p1_full   <= 1'b0;
          p2_full   <= 1'b0;
          wd_cnt    <= '0;
          ROUND_CNT <= 5'd0;
          TIMEOUT   <= 1'b0;
        end
        S_COLLECT: begin
          wd_cnt <= wd_cnt + CNT_W'(1);
          if (p1_acc) begin
            p1_lat  <= P1_MOVE;
            p1_full <= 1'b1;
          end
          if (p2_acc) begin
            p2_lat  <= P2_MOVE;
            p2_full <= 1'b1;
          end
          if (wd_expire) TIMEOUT <= 1'b1;
        end
        S_CAPTURE: begin
          RES_MANCHE  <= MANCHE;
          RES_PARTITA <= PARTITA;
          RES_VALID   <= 1'b1;
          if (MANCHE != 2'b00) ROUND_CNT <= sat_inc5(ROUND_CNT);
          p1_lat  <= 2'b00;
          p2_lat  <= 2'b00;
          p1_full <= 1'b0;
          p2_full <= 1'b0;
          wd_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_morra_match_ctrl.sv
// Self-checking bench for morra_match_ctrl with a small behavioural
// MorraCinese core (first player to three round wins takes the match).
module tb_morra_match_ctrl;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n, START, P1_VALID, P2_VALID;
  logic [3:0] CFG;
  logic [1:0] P1_MOVE, P2_MOVE;
  logic       P1_READY, P2_READY, INIZIO, RES_VALID, BUSY, MATCH_DONE, TIMEOUT;
  logic [1:0] PRIMO, SECONDO, RES_MANCHE, RES_PARTITA;
  logic [4:0] ROUND_CNT;
  logic [1:0] MANCHE = 2'b00;
  logic [1:0] PARTITA = 2'b00;
  logic [1:0] w1 = 2'd0;
  logic [1:0] w2 = 2'd0;
  logic [19:0] all_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] m;
    logic [1:0] p;
    logic [4:0] rc;
    logic       done;
  } res_t;

  res_t       exp_q[$];
  logic [3:0] iss_q[$];
  int         exp_rounds, exp_w1, exp_w2;

  morra_match_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .START(START), .CFG(CFG),
    .P1_VALID(P1_VALID), .P1_MOVE(P1_MOVE), .P2_VALID(P2_VALID), .P2_MOVE(P2_MOVE),
    .P1_READY(P1_READY), .P2_READY(P2_READY), .INIZIO(INIZIO),
    .PRIMO(PRIMO), .SECONDO(SECONDO), .MANCHE(MANCHE), .PARTITA(PARTITA),
    .RES_VALID(RES_VALID), .RES_MANCHE(RES_MANCHE), .RES_PARTITA(RES_PARTITA),
    .ROUND_CNT(ROUND_CNT), .BUSY(BUSY), .MATCH_DONE(MATCH_DONE), .TIMEOUT(TIMEOUT)
  );

  assign all_out = {P1_READY, P2_READY, INIZIO, PRIMO, SECONDO, RES_VALID,
                    RES_MANCHE, RES_PARTITA, ROUND_CNT, BUSY, MATCH_DONE, TIMEOUT};

  always #5 clk = ~clk;

  // Round rule: 01 sasso, 10 carta, 11 forbice; 01 = player 1, 10 = player 2, 11 = draw.
  function automatic logic [1:0] rule(input logic [1:0] a, input logic [1:0] b);
    if (a == b) return 2'b11;
    if ((a == 2'b01 && b == 2'b11) || (a == 2'b10 && b == 2'b01) ||
        (a == 2'b11 && b == 2'b10)) return 2'b01;
    return 2'b10;
  endfunction

  // Behavioural core: samples every edge; 00 moves are a no-op round.
  always @(posedge clk) begin
    if (INIZIO) begin
      MANCHE <= 2'b00; PARTITA <= 2'b00; w1 <= 2'd0; w2 <= 2'd0;
    end else if (PRIMO != 2'b00 && SECONDO != 2'b00) begin
      MANCHE <= rule(PRIMO, SECONDO);
      if (rule(PRIMO, SECONDO) == 2'b01) w1 <= w1 + 2'd1;
      if (rule(PRIMO, SECONDO) == 2'b10) w2 <= w2 + 2'd1;
      if (rule(PRIMO, SECONDO) == 2'b01 && w1 == 2'd2) PARTITA <= 2'b01;
      else if (rule(PRIMO, SECONDO) == 2'b10 && w2 == 2'd2) PARTITA <= 2'b10;
    end else begin
      MANCHE <= 2'b00;
    end
  end

  // Scoreboard monitor: compares issued moves and captured results.
  initial begin
    res_t       e;
    logic [3:0] ei;
    forever begin
      @(negedge clk);
      if (RES_VALID === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_result: got %h, none expected", {RES_MANCHE, RES_PARTITA, ROUND_CNT, MATCH_DONE});
        end else begin
          e = exp_q.pop_front();
          if ({RES_MANCHE, RES_PARTITA, ROUND_CNT, MATCH_DONE} !== e) begin
            errors++;
            $display("FAIL sb_result: got m=%b p=%b rc=%0d done=%b, exp m=%b p=%b rc=%0d done=%b",
                     RES_MANCHE, RES_PARTITA, ROUND_CNT, MATCH_DONE, e.m, e.p, e.rc, e.done);
          end
        end
      end
      if (INIZIO === 1'b0 && (PRIMO !== 2'b00 || SECONDO !== 2'b00)) begin
        checks++;
        if (iss_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_issue: got %b/%b", PRIMO, SECONDO);
        end else begin
          ei = iss_q.pop_front();
          if ({PRIMO, SECONDO} !== ei) begin
            errors++;
            $display("FAIL sb_issue: got %b/%b exp %b/%b", PRIMO, SECONDO, ei[3:2], ei[1:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_round(input logic [1:0] m1, input logic [1:0] m2);
    res_t e;
    e.m = rule(m1, m2);
    if (exp_rounds < 31) exp_rounds++;
    if (e.m == 2'b01) exp_w1++;
    if (e.m == 2'b10) exp_w2++;
    e.p    = (exp_w1 == 3) ? 2'b01 : (exp_w2 == 3) ? 2'b10 : 2'b00;
    e.rc   = 5'(exp_rounds);
    e.done = (e.p != 2'b00);
    exp_q.push_back(e);
    iss_q.push_back({m1, m2});
  endtask

  task automatic test_reset();
    rst_n = 1'b0; START = 1'b0; CFG = 4'h0;
    P1_VALID = 1'b0; P2_VALID = 1'b0; P1_MOVE = 2'b00; P2_MOVE = 2'b00;
    tick(); tick();
    checks++;
    if (all_out !== 20'h0) begin errors++; $display("FAIL reset_outputs: got %h exp 00000", all_out); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (all_out !== 20'h0) begin errors++; $display("FAIL idle_outputs: got %h exp 00000", all_out); end
  endtask

  task automatic test_start(input logic [3:0] cfg);
    exp_rounds = 0; exp_w1 = 0; exp_w2 = 0;
    START = 1'b1; CFG = cfg;
    tick();
    START = 1'b0;
    checks++;
    if ({INIZIO, SECONDO, PRIMO, BUSY, P1_READY, P2_READY} !== {1'b1, cfg, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL config_cycle: got ini=%b core=%b busy=%b rdy=%b%b exp ini=1 core=%b busy=1 rdy=00",
               INIZIO, {SECONDO, PRIMO}, BUSY, P1_READY, P2_READY, cfg);
    end
    tick();
    checks++;
    if ({INIZIO, P1_READY, P2_READY, BUSY, TIMEOUT, MATCH_DONE, ROUND_CNT} !== {5'b01110, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL collect_entry: got ini=%b rdy=%b%b busy=%b to=%b done=%b rc=%0d exp 0 11 1 0 0 0",
               INIZIO, P1_READY, P2_READY, BUSY, TIMEOUT, MATCH_DONE, ROUND_CNT);
    end
  endtask

  task automatic test_same_cycle();
    push_round(2'b10, 2'b01);
    P1_VALID = 1'b1; P1_MOVE = 2'b10; P2_VALID = 1'b1; P2_MOVE = 2'b01;
    tick();
    P1_VALID = 1'b0; P2_VALID = 1'b0;
    checks++;
    if ({PRIMO, SECONDO, P1_READY, P2_READY} !== 6'b100100) begin
      errors++; $display("FAIL issue_drive: got %b/%b rdy=%b%b exp 10/01 rdy=00", PRIMO, SECONDO, P1_READY, P2_READY);
    end
    tick();
    checks++;
    if ({PRIMO, SECONDO, RES_VALID, BUSY} !== 6'b000001) begin
      errors++; $display("FAIL capture_cycle: got %b/%b rv=%b busy=%b exp 00/00 rv=0 busy=1", PRIMO, SECONDO, RES_VALID, BUSY);
    end
    tick();
    checks++;
    if ({RES_VALID, RES_MANCHE, ROUND_CNT, P1_READY} !== {1'b1, 2'b01, 5'd1, 1'b1}) begin
      errors++; $display("FAIL first_result: got rv=%b m=%b rc=%0d rdy=%b exp rv=1 m=01 rc=1 rdy=1",
                         RES_VALID, RES_MANCHE, ROUND_CNT, P1_READY);
    end
    tick();
    checks++;
    if (RES_VALID !== 1'b0) begin errors++; $display("FAIL res_valid_pulse: got %b exp 0", RES_VALID); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] rv;
    rv = '0;
    push_round(2'b11, 2'b11);
    push_round(2'b11, 2'b11);
    P1_VALID = 1'b1; P1_MOVE = 2'b11; P2_VALID = 1'b1; P2_MOVE = 2'b11;
    for (int i = 0; i < 7; i++) begin
      tick();
      rv[i] = RES_VALID;
      if (i == 3) begin P1_VALID = 1'b0; P2_VALID = 1'b0; end
    end
    checks++;
    if (rv !== 7'b0100100) begin errors++; $display("FAIL back_to_back_period: got %b exp 0100100", rv); end
  endtask

  task automatic test_hold();
    push_round(2'b11, 2'b10);
    P1_VALID = 1'b1; P1_MOVE = 2'b11;
    tick();
    P1_MOVE = 2'b01;
    checks++;
    if ({P1_READY, P2_READY} !== 2'b01) begin
      errors++; $display("FAIL hold_ready: got %b%b exp 01", P1_READY, P2_READY);
    end
    for (int k = 0; k < 4; k++) tick();
    P2_VALID = 1'b1; P2_MOVE = 2'b10;
    tick();
    P1_VALID = 1'b0; P2_VALID = 1'b0;
    checks++;
    if ({PRIMO, SECONDO} !== 4'b1110) begin
      errors++; $display("FAIL hold_issue: got %b/%b exp 11/10", PRIMO, SECONDO);
    end
    tick(); tick();
    checks++;
    if ({RES_VALID, RES_MANCHE, ROUND_CNT} !== {1'b1, 2'b01, 5'd4}) begin
      errors++; $display("FAIL hold_result: got rv=%b m=%b rc=%0d exp rv=1 m=01 rc=4", RES_VALID, RES_MANCHE, ROUND_CNT);
    end
  endtask

  task automatic test_zero_move();
    push_round(2'b11, 2'b11);
    P1_VALID = 1'b1; P1_MOVE = 2'b11; P2_VALID = 1'b1; P2_MOVE = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick();
      P1_VALID = 1'b0;
      checks++;
      if ({P2_READY, BUSY, PRIMO, SECONDO} !== 6'b110000) begin
        errors++; $display("FAIL zero_move_ready: got rdy=%b busy=%b core=%b/%b exp rdy=1 busy=1 00/00",
                           P2_READY, BUSY, PRIMO, SECONDO);
      end
    end
    P2_MOVE = 2'b11;
    tick();
    P2_VALID = 1'b0;
    checks++;
    if ({PRIMO, SECONDO} !== 4'b1111) begin
      errors++; $display("FAIL zero_move_issue: got %b/%b exp 11/11", PRIMO, SECONDO);
    end
    tick(); tick();
    checks++;
    if ({RES_VALID, RES_MANCHE, ROUND_CNT} !== {1'b1, 2'b11, 5'd5}) begin
      errors++; $display("FAIL zero_move_result: got rv=%b m=%b rc=%0d exp rv=1 m=11 rc=5", RES_VALID, RES_MANCHE, ROUND_CNT);
    end
  endtask

  task automatic test_timeout();
    int inizio_seen;
    inizio_seen = 0;
    P1_VALID = 1'b1; P1_MOVE = 2'b01;
    for (int k = 1; k <= TO; k++) begin
      tick();
      P1_VALID = 1'b0;
      if (INIZIO) inizio_seen++;
      checks++;
      if ({TIMEOUT, MATCH_DONE} !== {2{k == TO}}) begin
        errors++; $display("FAIL timeout_edge%0d: got to=%b done=%b exp %b", k, TIMEOUT, MATCH_DONE, k == TO);
      end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (INIZIO) inizio_seen++;
    end
    checks++;
    if ({TIMEOUT, MATCH_DONE, BUSY, P1_READY, P2_READY} !== 5'b11000 || inizio_seen != 0) begin
      errors++; $display("FAIL timeout_hold: got to=%b done=%b busy=%b rdy=%b%b inizio=%0d exp 1 1 0 00 0",
                         TIMEOUT, MATCH_DONE, BUSY, P1_READY, P2_READY, inizio_seen);
    end
  endtask

  task automatic test_final_round();
    for (int r = 0; r < 3; r++) begin
      push_round(2'b01, 2'b10);
      P1_VALID = 1'b1; P1_MOVE = 2'b01; P2_VALID = 1'b1; P2_MOVE = 2'b10;
      START = (r == 1);
      tick();
      P1_VALID = 1'b0; P2_VALID = 1'b0;
      tick();
      START = 1'b0;
      checks++;
      if ({INIZIO, BUSY} !== 2'b01) begin
        errors++; $display("FAIL midmatch_start_r%0d: got ini=%b busy=%b exp ini=0 busy=1", r, INIZIO, BUSY);
      end
      tick();
      checks++;
      if ({RES_VALID, RES_MANCHE, RES_PARTITA, ROUND_CNT, MATCH_DONE} !==
          {1'b1, 2'b10, (r == 2) ? 2'b10 : 2'b00, 5'(r + 1), r == 2}) begin
        errors++; $display("FAIL final_r%0d: got rv=%b m=%b p=%b rc=%0d done=%b", r,
                           RES_VALID, RES_MANCHE, RES_PARTITA, ROUND_CNT, MATCH_DONE);
      end
    end
    tick();
    checks++;
    if ({MATCH_DONE, BUSY, RES_VALID, P1_READY, P2_READY, TIMEOUT} !== 6'b100000) begin
      errors++; $display("FAIL done_hold: got done=%b busy=%b rv=%b rdy=%b%b to=%b exp 1 0 0 00 0",
                         MATCH_DONE, BUSY, RES_VALID, P1_READY, P2_READY, TIMEOUT);
    end
  endtask

  task automatic test_reset_mid();
    START = 1'b1; CFG = 4'h0;
    tick();
    START = 1'b0;
    tick();
    P1_VALID = 1'b1; P1_MOVE = 2'b11;
    tick();
    P1_VALID = 1'b0;
    checks++;
    if ({P1_READY, P2_READY, BUSY} !== 3'b011) begin
      errors++; $display("FAIL reset_mid_pre: got rdy=%b%b busy=%b exp 01 1", P1_READY, P2_READY, BUSY);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (all_out !== 20'h0) begin errors++; $display("FAIL reset_mid_outputs: got %h exp 00000", all_out); end
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (all_out !== 20'h0) begin errors++; $display("FAIL reset_mid_idle: got %h exp 00000", all_out); end
  endtask

  task automatic test_end();
    checks++;
    if (exp_q.size() != 0 || iss_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d results %0d issues pending exp 0 0", exp_q.size(), iss_q.size());
    end
  endtask

  initial begin
    exp_rounds = 0; exp_w1 = 0; exp_w2 = 0;
    test_reset();
    test_start(4'b0000);
    test_same_cycle();
    test_back_to_back();
    test_hold();
    test_zero_move();
    test_timeout();
    test_start(4'b0110);
    test_final_round();
    test_reset_mid();
    tick();
    test_end();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
